dmem_responder: RTL and testbench

Single-port data memory that acts as the responder to the core's memory-stage interface. It accepts one read or write request at a time on the request/we_re/mask handshake, applies programmable wait states, and completes each transaction with a one-cycle `valid` pulse carrying load data. It sits outside the core, attached to the `data_mem_*`, `alu_out_address`, `store_data_out` and `load_data_in` nets. It serves as both the simulation memory model and the FPGA block-RAM wrapper.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder with programmable wait states and a one-cycle valid pulse.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag (and suppress) out-of-range accesses via err.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [31:0] addr_r;
  logic        we_r;
  logic [3:0]  mask_r;
  logic [31:0] data_r;
  logic        valid_r;
  logic [31:0] load_data_r;
  logic        err_r;

  logic [31:0] sel_addr_s;
  logic        sel_we_s;
  logic [3:0]  sel_mask_s;
  logic [31:0] sel_data_s;
  logic [AW-1:0] word_idx_s;
  logic        commit_s;
  logic        oob_s;
  logic        unused_s;

  logic [31:0] mem_r [DEPTH];

  // Next-state logic and transaction source select
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (request) begin
          state_nxt_s = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the capture edge, so use the live inputs then
  always_comb begin
    if (state_r == IDLE) begin
      sel_addr_s = address;
      sel_we_s   = we_re;
      sel_mask_s = mask;
      sel_data_s = store_data;
    end else begin
      sel_addr_s = addr_r;
      sel_we_s   = we_r;
      sel_mask_s = mask_r;
      sel_data_s = data_r;
    end
  end

  assign word_idx_s = sel_addr_s[AW+1:2];
  assign commit_s   = (state_nxt_s == RESP);
  assign unused_s   = ^{sel_addr_s[1:0], sel_addr_s[31:AW+2]};

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_s = (sel_addr_s[31:2] >= 30'(DEPTH));
`else
  assign oob_s = 1'b0;
`endif

  // Control registers, request capture and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= 32'd0;
      we_r        <= 1'b0;
      mask_r      <= 4'd0;
      data_r      <= 32'd0;
      valid_r     <= 1'b0;
      load_data_r <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= commit_s;
      err_r   <= commit_s && oob_s;
      if (commit_s && !sel_we_s && !oob_s) begin
        load_data_r <= mem_r[word_idx_s];
      end else begin
        load_data_r <= 32'd0;
      end
      if ((state_r == IDLE) && request) begin
        addr_r <= address;
        we_r   <= we_re;
        mask_r <= mask;
        data_r <= store_data;
        cnt_r  <= 4'(WAIT_CYCLES);
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Byte-lane write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && commit_s && sel_we_s && !oob_s) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_mask_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= sel_data_s[8*i +: 8];
        end
      end
    end
  end

  assign valid     = valid_r;
  assign load_data = load_data_r;
  assign err       = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: three instances (WAIT_CYCLES = 1, 0, 3).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_re = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        req1 = 1'b0;
  logic        req0 = 1'b0;
  logic        req3 = 1'b0;
  logic        v1, v0, v3;
  logic        e1, e0, e3;
  logic [31:0] ld1, ld0, ld3;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .request(req1), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data), .valid(v1), .load_data(ld1), .err(e1));
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .request(req0), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data), .valid(v0), .load_data(ld0), .err(e0));
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .request(req3), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data), .valid(v3), .load_data(ld3), .err(e3));

  // Issue one transaction on dut1 and return latency (negedges until valid, -1 on timeout)
  task automatic txn1(input logic we, input logic [3:0] m, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic e);
    @(negedge clk);
    req1 = 1'b1; we_re = we; mask = m; address = a; store_data = d;
    lat = -1; rd = 32'h0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (v1) begin
        lat = i; rd = ld1; e = e1;
        break;
      end
    end
    req1 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({v1, v0, v3} !== 3'b000) begin
      n_bad++; $display("FAIL reset_valid: got %b expected 000", {v1, v0, v3});
    end
    n_cmp++;
    if ((ld1 | ld0 | ld3) !== 32'h0) begin
      n_bad++; $display("FAIL reset_load_data: got %h expected 00000000", ld1 | ld0 | ld3);
    end
    n_cmp++;
    if ({e1, e0, e3} !== 3'b000) begin
      n_bad++; $display("FAIL reset_err: got %b expected 000", {e1, e0, e3});
    end
    rst = 1'b0;
  endtask

  task automatic test_full_word;
    int lat; logic [31:0] rd; logic e;
    txn1(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, e);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL write_latency: got %0d expected 2", lat); end
    txn1(1'b0, 4'hF, 32'h10, 32'h0, lat, rd, e);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL read_latency: got %0d expected 2", lat); end
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_full: got %h expected deadbeef", rd); end
    @(negedge clk);
    n_cmp++;
    if ({v1, ld1} !== {1'b0, 32'h0}) begin
      n_bad++; $display("FAIL load_data_idle: got v=%b d=%h expected v=0 d=00000000", v1, ld1);
    end
  endtask

  task automatic test_byte_lane;
    int lat; logic [31:0] rd; logic e;
    txn1(1'b1, 4'b0010, 32'h10, 32'h0000AB00, lat, rd, e);
    txn1(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'hDEADABEF) begin n_bad++; $display("FAIL byte_lane: got %h expected deadabef", rd); end
    txn1(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, lat, rd, e);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL mask0_valid: got %0d expected 2", lat); end
    txn1(1'b0, 4'hF, 32'h10, 32'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'hDEADABEF) begin n_bad++; $display("FAIL mask0_data: got %h expected deadabef", rd); end
  endtask

  // Held request: first valid at W+1 after acceptance, re-accepted next cycle, second valid W+2 later
  task automatic test_latency(input int w);
    int c0, c1, c2; logic vv; logic [31:0] dd;
    @(negedge clk);
    we_re = 1'b0; mask = 4'hF; address = 32'h10;
    if (w == 0) req0 = 1'b1; else req3 = 1'b1;
    c0 = cyc; c1 = -100; c2 = -100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vv = (w == 0) ? v0 : v3;
      if (vv) begin c1 = cyc; break; end
    end
    n_cmp++;
    if (c1 - c0 !== w + 1) begin
      n_bad++; $display("FAIL latency_w%0d: got %0d expected %0d", w, c1 - c0, w + 1);
    end
    @(negedge clk);
    vv = (w == 0) ? v0 : v3;
    dd = (w == 0) ? ld0 : ld3;
    n_cmp++;
    if ({vv, dd} !== {1'b0, 32'h0}) begin
      n_bad++; $display("FAIL pulse_width_w%0d: got v=%b d=%h expected v=0 d=00000000", w, vv, dd);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vv = (w == 0) ? v0 : v3;
      if (vv) begin c2 = cyc; break; end
    end
    req0 = 1'b0; req3 = 1'b0;
    n_cmp++;
    if (c2 - c1 !== w + 2) begin
      n_bad++; $display("FAIL reaccept_w%0d: got %0d expected %0d", w, c2 - c1, w + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] rd; logic e; int seen;
    txn1(1'b1, 4'hF, 32'h20, 32'h11112222, lat, rd, e);
    @(negedge clk);
    req1 = 1'b1; we_re = 1'b1; mask = 4'hF; address = 32'h20; store_data = 32'h12345678;
    @(negedge clk);
    rst = 1'b1; req1 = 1'b0;
    seen = 0;
    @(negedge clk);
    seen = seen + int'(v1);
    rst = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen + int'(v1); end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL abort_valid: got %0d pulses expected 0", seen); end
    txn1(1'b0, 4'hF, 32'h20, 32'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'h11112222) begin n_bad++; $display("FAIL abort_data: got %h expected 11112222", rd); end
  endtask

  task automatic test_bounds;
    int lat; logic [31:0] rd; logic e;
    txn1(1'b1, 4'hF, 32'h0, 32'h13579BDF, lat, rd, e);
    txn1(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, lat, rd, e);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL oob_valid: got %0d expected 2", lat); end
`ifdef DMEM_BOUNDS_CHECK_EN
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL oob_err: got %b expected 1", e); end
    txn1(1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'h13579BDF) begin n_bad++; $display("FAIL oob_word0: got %h expected 13579bdf", rd); end
`else
    n_cmp++;
    if (e !== 1'b0) begin n_bad++; $display("FAIL oob_err: got %b expected 0", e); end
    txn1(1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL oob_alias: got %h expected cafef00d", rd); end
`endif
    n_cmp++;
    if (e !== 1'b0) begin n_bad++; $display("FAIL inrange_err: got %b expected 0", e); end
  endtask

  task automatic test_back_to_back;
    int c1, c2; logic [31:0] rd;
    @(negedge clk);
    req1 = 1'b1; we_re = 1'b1; mask = 4'hF; address = 32'h40; store_data = 32'hA5A5A5A5;
    c1 = -100; c2 = -100; rd = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v1) begin c1 = cyc; break; end
    end
    we_re = 1'b0; store_data = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v1) begin c2 = cyc; rd = ld1; break; end
    end
    req1 = 1'b0;
    n_cmp++;
    if (c2 - c1 !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 3", c2 - c1); end
    n_cmp++;
    if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL b2b_data: got %h expected a5a5a5a5", rd); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_full_word;
    test_byte_lane;
    test_latency(0);
    test_latency(3);
    test_reset_abort;
    test_bounds;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
